// File: rtl/btn_conditioner_pkg.sv
// Shared types and constants for the pushbutton conditioning front end.
// Channel indices also give the bit positions inside the held vector.
package btn_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } btn_state_e;

   localparam int BTN_LEFT  = 0;
   localparam int BTN_RIGHT = 1;
   localparam int BTN_UP    = 2;
   localparam int NUM_BTN   = 3;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, debounce FSM with down-counting
// timers, press one-shot and optional hold-to-repeat.
//
//   state        | meaning
//   -------------+------------------------------------------------------------
//   IDLE         | released and accepted as released; counters cleared
//   PRESS_WAIT   | candidate press, counting stable high samples
//   HELD         | press accepted; repeat timer running when enabled
//   RELEASE_WAIT | candidate release, counting stable low samples; repeat frozen
module btn_debounce
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic pulse,
   output logic held
);

   localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] DB_LOAD   = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY);
   localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
   localparam bit               DB_SINGLE = (DEBOUNCE_CYCLES == 1);
   localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

   logic             sync1_q, sync2_q;
   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             press_q, press_d;
   logic             pulse_q, pulse_d;
   logic             held_q, held_d;
   logic             rpt_fire;
   logic             s;

   assign s = sync2_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         state_q   <= IDLE;
         db_cnt_q  <= CNT_ZERO;
         rpt_cnt_q <= CNT_ZERO;
         press_q   <= 1'b0;
         pulse_q   <= 1'b0;
         held_q    <= 1'b0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         state_q   <= state_d;
         db_cnt_q  <= db_cnt_d;
         rpt_cnt_q <= rpt_cnt_d;
         press_q   <= press_d;
         pulse_q   <= pulse_d;
         held_q    <= held_d;
      end
   end

   // db_cnt holds the number of further stable samples still needed; the
   // sample that finds it at one is the last one and completes acceptance.
   always_comb begin
      state_d   = state_q;
      db_cnt_d  = db_cnt_q;
      rpt_cnt_d = rpt_cnt_q;
      press_d   = 1'b0;
      rpt_fire  = 1'b0;

      case (state_q)
         IDLE: begin
            db_cnt_d  = CNT_ZERO;
            rpt_cnt_d = CNT_ZERO;
            if (s) begin
               if (DB_SINGLE) begin
                  state_d   = HELD;
                  press_d   = 1'b1;
                  rpt_cnt_d = RPT_FIRST;
               end else begin
                  state_d  = PRESS_WAIT;
                  db_cnt_d = DB_LOAD;
               end
            end
         end

         PRESS_WAIT: begin
            if (!s) begin
               state_d  = IDLE;
               db_cnt_d = CNT_ZERO;
            end else if (db_cnt_q <= CNT_ONE) begin
               state_d   = HELD;
               db_cnt_d  = CNT_ZERO;
               press_d   = 1'b1;
               rpt_cnt_d = RPT_FIRST;
            end else begin
               db_cnt_d = db_cnt_q - CNT_ONE;
            end
         end

         HELD: begin
            if (!s) begin
               if (DB_SINGLE) begin
                  state_d   = IDLE;
                  rpt_cnt_d = CNT_ZERO;
               end else begin
                  state_d  = RELEASE_WAIT;
                  db_cnt_d = DB_LOAD;
               end
            end else if (REPEAT_EN) begin
               // A due repeat waits one cycle if the previous cycle already
               // pulsed, which keeps same-channel pulses at least 2 apart.
               if (rpt_cnt_q == CNT_ZERO) begin
                  if (!pulse_q) begin
                     rpt_fire  = 1'b1;
                     rpt_cnt_d = RPT_NEXT;
                  end
               end else begin
                  rpt_cnt_d = rpt_cnt_q - CNT_ONE;
               end
            end
         end

         RELEASE_WAIT: begin
            if (s) begin
               state_d  = HELD;
               db_cnt_d = CNT_ZERO;
            end else if (db_cnt_q <= CNT_ONE) begin
               state_d   = IDLE;
               db_cnt_d  = CNT_ZERO;
               rpt_cnt_d = CNT_ZERO;
            end else begin
               db_cnt_d = db_cnt_q - CNT_ONE;
            end
         end

         default: begin
            state_d   = IDLE;
            db_cnt_d  = CNT_ZERO;
            rpt_cnt_d = CNT_ZERO;
         end
      endcase
   end

   // Outputs are registered off the FSM state so pulse and held line up.
   always_comb begin
      pulse_d = press_q | rpt_fire;
      held_d  = (state_q == HELD) || (state_q == RELEASE_WAIT);
   end

   assign pulse = pulse_q;
   assign held  = held_q;

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the three raw board buttons into single-cycle move pulses
// and debounced held levels for the game core.
module btn_conditioner
   import btn_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 20000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       raw_left,
   input  logic       raw_right,
   input  logic       raw_up,
   output logic       btn_left,
   output logic       btn_right,
   output logic       btn_up,
   output logic [2:0] held
);

   logic [NUM_BTN-1:0] raw_vec;
   logic [NUM_BTN-1:0] pulse_vec;
   logic [NUM_BTN-1:0] held_vec;

   assign raw_vec[BTN_LEFT]  = raw_left;
   assign raw_vec[BTN_RIGHT] = raw_right;
   assign raw_vec[BTN_UP]    = raw_up;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (raw_vec[i]),
         .pulse (pulse_vec[i]),
         .held  (held_vec[i])
      );
   end

   assign btn_left  = pulse_vec[BTN_LEFT];
   assign btn_right = pulse_vec[BTN_RIGHT];
   assign btn_up    = pulse_vec[BTN_UP];
   assign held      = held_vec;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one instance without repeat, one with
// REPEAT_DELAY=10 / REPEAT_PERIOD=5, both with DEBOUNCE_CYCLES=4.
module tb_btn_conditioner;

   logic       clk = 1'b0;
   logic       reset;
   logic       raw_left, raw_right, raw_up;
   logic       btn_left, btn_right, btn_up;
   logic [2:0] held;

   logic       r_raw_left, r_raw_right, r_raw_up;
   logic       r_btn_left, r_btn_right, r_btn_up;
   logic [2:0] r_held;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (0),
      .REPEAT_PERIOD   (5)
   ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .raw_left  (raw_left),
      .raw_right (raw_right),
      .raw_up    (raw_up),
      .btn_left  (btn_left),
      .btn_right (btn_right),
      .btn_up    (btn_up),
      .held      (held)
   );

   btn_conditioner #(
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) u_rpt (
      .clk       (clk),
      .reset     (reset),
      .raw_left  (r_raw_left),
      .raw_right (r_raw_right),
      .raw_up    (r_raw_up),
      .btn_left  (r_btn_left),
      .btn_right (r_btn_right),
      .btn_up    (r_btn_up),
      .held      (r_held)
   );

   task automatic check(input string tag, input int e, input logic [2:0] obs,
                        input logic [2:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s edge %0d: observed %b expected %b", tag, e, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs set before this call
   // are sampled on that edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset       = 1'b0;
      raw_left    = 1'b0;
      raw_right   = 1'b0;
      raw_up      = 1'b0;
      r_raw_left  = 1'b0;
      r_raw_right = 1'b0;
      r_raw_up    = 1'b0;

      // Reset: outputs stay low even with a button pressed
      raw_left = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         check("rst_btn", e, {btn_up, btn_right, btn_left}, 3'b000);
         check("rst_held", e, held, 3'b000);
         check("rst_rpt_held", e, r_held, 3'b000);
      end
      raw_left = 1'b0;
      step();
      reset = 1'b1;
      for (int e = 1; e <= 10; e++) step();
      check("idle_held", 0, held, 3'b000);

      // Clean press: raw high edges 10..29
      for (int e = 1; e <= 45; e++) begin
         raw_left = (e >= 10 && e < 30);
         step();
         check("clean_btn", e, {btn_up, btn_right, btn_left},
               (e == 16) ? 3'b001 : 3'b000);
         check("clean_held", e, held, (e >= 16 && e < 36) ? 3'b001 : 3'b000);
      end

      // Bounce rejection: 1,1,1,0 pattern never reaches 4 stable samples
      for (int e = 1; e <= 48; e++) begin
         raw_up = (e <= 40) && (((e - 1) % 4) != 3);
         step();
         check("bounce_btn", e, {btn_up, btn_right, btn_left}, 3'b000);
         check("bounce_held", e, held, 3'b000);
      end

      // Release bounce: 2-sample low glitch at edges 20,21 while held
      for (int e = 1; e <= 52; e++) begin
         raw_left = (e <= 40) && !(e == 20 || e == 21);
         step();
         check("relb_btn", e, {btn_up, btn_right, btn_left},
               (e == 7) ? 3'b001 : 3'b000);
         check("relb_held", e, held, (e >= 7 && e < 47) ? 3'b001 : 3'b000);
      end

      // Repeat: raw_right high edges 10..39
      for (int e = 1; e <= 55; e++) begin
         r_raw_right = (e >= 10 && e < 40);
         step();
         check("rpt_btn", e, {r_btn_up, r_btn_right, r_btn_left},
               (e inside {16, 26, 31, 36, 41}) ? 3'b010 : 3'b000);
         check("rpt_held", e, r_held, (e >= 16 && e < 46) ? 3'b010 : 3'b000);
      end

      // Simultaneous left+up press on the same edge
      for (int e = 1; e <= 40; e++) begin
         raw_left = (e >= 10 && e < 25);
         raw_up   = (e >= 10 && e < 25);
         step();
         check("simul_btn", e, {btn_up, btn_right, btn_left},
               (e == 16) ? 3'b101 : 3'b000);
         check("simul_held", e, held, (e >= 16 && e < 31) ? 3'b101 : 3'b000);
      end

      // Reset after the third PRESS_WAIT cycle, held low for 5 edges
      for (int e = 1; e <= 35; e++) begin
         raw_left = (e >= 10);
         step();
         if (e == 14) begin
            reset = 1'b0;
            #1;
         end
         if (e == 19) begin
            reset = 1'b1;
            #1;
         end
         check("rstmid_btn", e, {btn_up, btn_right, btn_left},
               (e == 26) ? 3'b001 : 3'b000);
         check("rstmid_held", e, held, (e >= 26) ? 3'b001 : 3'b000);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
